// File: rtl/psram_pkg.sv
// ============================================================================
// psram_pkg : shared constants for the PSRAM arbiter front end
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package psram_pkg;

  localparam int PSRAM_ADDR_W = 23;
  localparam int PSRAM_DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_POWERUP  = 2'd0;
  localparam state_t ST_IDLE     = 2'd1;
  localparam state_t ST_ISSUE    = 2'd2;
  localparam state_t ST_WAIT_RSP = 2'd3;

  localparam logic OWNER_R0 = 1'b0;
  localparam logic OWNER_R1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/psram_rr_pick.sv
// ============================================================================
// psram_rr_pick : two-way round-robin select; on a tie the loser of the last
//                 grant wins.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module psram_rr_pick
  import psram_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_pick
);

  logic w_tie_pick;

  assign w_tie_pick = (i_last_grant == OWNER_R0) ? OWNER_R1 : OWNER_R0;
  assign o_valid    = |i_req;
  assign o_pick     = (i_req == 2'b11) ? w_tie_pick
                    : (i_req[1] ? OWNER_R1 : OWNER_R0);

endmodule

`default_nettype wire

// File: rtl/psram_arbiter.sv
// ============================================================================
// psram_arbiter : power-up gated round-robin arbiter issuing one outstanding
//                 command to the PSRAM core, with response timeout.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module psram_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W         = PSRAM_ADDR_W,
  parameter int DATA_W         = PSRAM_DATA_W,
  parameter int POWERUP_CYCLES = 2048,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  output logic              ready,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [7:0]        timeout_count
);

  localparam int PU_W = $clog2(POWERUP_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PU_W-1:0] c_PU_LAST = PU_W'(POWERUP_CYCLES - 1);
  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [PU_W-1:0]   r_pu_cnt;
  logic [TO_W-1:0]   r_tcnt;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_ready;
  logic              r_cmd_valid;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_r0_rdata;
  logic [DATA_W-1:0] r_r1_rdata;
  logic [7:0]        r_to_cnt;

  logic w_pick_valid;
  logic w_pick;

  psram_rr_pick u_pick (
    .i_req        ({r1_req, r0_req}),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_pick       (w_pick)
  );

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state      <= ST_POWERUP;
      r_pu_cnt     <= '0;
      r_tcnt       <= '0;
      r_owner      <= OWNER_R0;
      r_last_grant <= OWNER_R1;
      r_ready      <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_gnt        <= 2'b00;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
      r_to_cnt     <= 8'd0;
    end else begin
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
      case (r_state)
        ST_POWERUP: begin
          r_pu_cnt <= r_pu_cnt + 1'b1;
          if (r_pu_cnt == c_PU_LAST) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_owner     <= w_pick;
            r_cmd_we    <= (w_pick == OWNER_R1) ? r1_we    : r0_we;
            r_cmd_addr  <= (w_pick == OWNER_R1) ? r1_addr  : r0_addr;
            r_cmd_wdata <= (w_pick == OWNER_R1) ? r1_wdata : r0_wdata;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid    <= 1'b0;
            r_gnt[r_owner] <= 1'b1;
            r_tcnt         <= '0;
            r_state        <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // A response arriving on the expiry cycle still counts as success.
          if (rsp_valid || (r_tcnt == c_TO_LAST)) begin
            r_done[r_owner] <= 1'b1;
            r_err[r_owner]  <= ~rsp_valid;
            if (r_owner == OWNER_R1) begin
              r_r1_rdata <= (rsp_valid && !r_cmd_we) ? rsp_rdata : '0;
            end else begin
              r_r0_rdata <= (rsp_valid && !r_cmd_we) ? rsp_rdata : '0;
            end
            if (!rsp_valid && (r_to_cnt != 8'hFF)) begin
              r_to_cnt <= r_to_cnt + 8'd1;
            end
            r_last_grant <= r_owner;
            r_state      <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= ST_POWERUP;
      endcase
    end
  end

  assign ready         = r_ready;
  assign cmd_valid     = r_cmd_valid;
  assign cmd_we        = r_cmd_we;
  assign cmd_addr      = r_cmd_addr;
  assign cmd_wdata     = r_cmd_wdata;
  assign r0_gnt        = r_gnt[0];
  assign r1_gnt        = r_gnt[1];
  assign r0_done       = r_done[0];
  assign r1_done       = r_done[1];
  assign r0_err        = r_err[0];
  assign r1_err        = r_err[1];
  assign r0_rdata      = r_r0_rdata;
  assign r1_rdata      = r_r1_rdata;
  assign timeout_count = r_to_cnt;

endmodule

`default_nettype wire

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the PSRAM controller core (`psram`).
- Holds off all traffic until the PSRAM power-up interval has elapsed.
- Grants one requester at a time and drives a single-outstanding command to the core over a valid/ready handshake.
- Routes the completion (read data or write ack) back to the owning requester, with a response timeout so a hung core cannot lock the bus.

Parameters:
- ADDR_W, 23, byte address width (64 Mbit PSRAM).
- DATA_W, 8, data width per transaction.
- POWERUP_CYCLES, 2048, cycles after reset before any command is issued (≥150 µs at 13.5 MHz).
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_RSP before forced completion with error.

Ports:
- sys_clk  in  1  clock.
- sys_reset_n  in  1  asynchronous, active-low reset.
- ready  out  1  high once power-up wait is complete.
- r0_req  in  1  requester 0 request; held with fields stable until r0_gnt.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  ADDR_W  address.
- r0_wdata  in  DATA_W  write data.
- r0_gnt  out  1  one-cycle pulse: command accepted by core.
- r0_done  out  1  one-cycle pulse: transaction complete.
- r0_rdata  out  DATA_W  read data, valid with r0_done.
- r0_err  out  1  valid with r0_done: timeout occurred.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata, r1_err: identical for requester 1.
- cmd_valid  out  1  command valid to core.
- cmd_ready  in  1  core accepts command.
- cmd_we  out  1  command direction.
- cmd_addr  out  ADDR_W  command address.
- cmd_wdata  out  DATA_W  command write data.
- rsp_valid  in  1  core completion pulse (reads and writes).
- rsp_rdata  in  DATA_W  read data, valid with rsp_valid.
- timeout_count  out  8  saturating count of timeouts since reset.

Behaviour:
- Reset (async, immediate):
  - All outputs 0; cmd_valid drops combinationally-free, directly from reset flops.
  - state = POWERUP, powerup counter = 0, last_grant = 1 (so requester 0 wins first).
- POWERUP:
  - Counter increments each cycle.
  - At count == POWERUP_CYCLES-1: ready <= 1 next cycle, go IDLE.
  - Requests are ignored, never granted, never lost; they stay pending.
- IDLE:
  - If only one req is high, select it.
  - If both are high, select the requester != last_grant.
  - Latch we/addr/wdata into cmd_* and owner into a register; cmd_valid <= 1; go ISSUE.
  - Latency: req sampled at cycle N gives cmd_valid high at N+1.
- ISSUE:
  - cmd_valid and cmd_* held stable until cmd_ready.
  - On the cmd_valid & cmd_ready cycle: cmd_valid <= 0, owner gnt pulses the next cycle, timeout counter cleared, go WAIT_RSP.
- WAIT_RSP:
  - On rsp_valid: owner rdata <= rsp_rdata (writes: rdata <= 0), done pulses one cycle, err = 0, last_grant <= owner, go IDLE.
  - If the timeout counter reaches TIMEOUT_CYCLES first: done pulses with err = 1, rdata = 0, timeout_count saturates at 255, last_grant <= owner, go IDLE.
- rsp_valid outside WAIT_RSP is ignored.
- rsp_valid on the same cycle the timeout expires counts as a normal completion (err = 0).
- gnt and done never assert for both requesters in the same cycle; at most one transaction is outstanding.
- A requester may drop req only after gnt. Dropping it before gnt is a protocol violation: the latched command still completes.
- IDLE → next ISSUE takes a minimum of 1 cycle, so back-to-back transactions are spaced by ≥1 idle cycle.
- rdata holds its value until the next done for that port.

Decomposition:
- Package psram_pkg: state enum {POWERUP, IDLE, ISSUE, WAIT_RSP}, ADDR_W/DATA_W defaults, and owner encoding constants.
- One natural sub-module: psram_rr_pick (2-way round-robin select from req[1:0] and last_grant). Everything else stays in the top FSM.

Test Plan:
- Reset, r0_req = 1 immediately → no cmd_valid for 2048 cycles; ready rises at cycle 2048; cmd_valid the next cycle with r0_addr.
- After ready, r0 read addr 0x000123, core answers rsp_rdata = 0xA5 three cycles after accept → r0_gnt one pulse, r0_done pulse with r0_rdata = 0xA5, r0_err = 0.
- Both requesters held high continuously for 4 transactions → grant order r0, r1, r0, r1; never two gnt or two done in one cycle.
- cmd_ready held low 10 cycles → cmd_valid/addr/we/wdata stable all 10 cycles; gnt only after the ready cycle.
- No rsp_valid after accept → done with err = 1 exactly 255 cycles after entering WAIT_RSP; timeout_count = 1; the next request proceeds normally.
- sys_reset_n low mid-WAIT_RSP → all outputs 0 asynchronously; after release, POWERUP repeats in full and the late rsp_valid is ignored.
